// File: rtl/chunked_serial_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder_if
//
// Purpose: groups the operand/result handshake of chunked_serial_adder into
// one bundle so the adder and its producer/consumer share a single port.
//
// Signals (WIDTH = operand/result width):
//   in_valid   producer -> adder   operands valid
//   in_ready   adder -> producer   adder idle, can accept
//   a, b       producer -> adder   operands (WIDTH bits)
//   cin        producer -> adder   carry-in, used for add only
//   sub        producer -> adder   1 = a - b, 0 = a + b + cin
//   out_valid  adder -> consumer   result valid
//   out_ready  consumer -> adder   consumer accepts result
//   sum        adder -> consumer   result (WIDTH bits)
//   cout       adder -> consumer   final carry-out (sub: 1 = no borrow)
//   overflow   adder -> consumer   signed overflow
//
// Modports: master = producer/consumer side, slave = the adder.
// ---------------------------------------------------------------------------
interface chunked_serial_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//
// Purpose: multi-cycle adder/subtractor. WIDTH-bit operands are processed in
// CHUNK-bit slices, one slice per clock starting at the least significant
// slice, with the carry between slices held in a register. An operation takes
// NCHUNK = WIDTH/CHUNK cycles in RUN; the result is then held in DONE until
// the consumer takes it. WIDTH must be a multiple of CHUNK.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; aborts any operation in flight
//   bus   chunked_serial_adder_if.slave (in_valid/in_ready, a, b, cin, sub,
//         out_valid/out_ready, sum, cout, overflow)
//
// Configuration macro: CHUNK_SERIAL_ADDER_OVERFLOW_EN
//   defined   - overflow reports signed overflow of the completed operation
//   undefined - overflow is tied to 0 and no overflow logic is built
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    chunked_serial_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    // A single-slice build still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             cout_reg;
    logic [CNT_W-1:0] cnt;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   slice_add;

    // Select the current slice of both latched operands and add it with the
    // running carry; the extra top bit is the slice carry-out.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_slice = a_reg[i*CHUNK +: CHUNK];
                b_slice = b_reg[i*CHUNK +: CHUNK];
            end
        end
        slice_add = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
    end

    // Control FSM and datapath registers. Subtraction is a + ~b + 1, so the
    // operand is inverted once at accept time and the initial carry forced
    // to 1; cin only matters for additions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? 1'b1 : bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            sum_reg[i*CHUNK +: CHUNK] <= slice_add[CHUNK-1:0];
                        end
                    end
                    carry <= slice_add[CHUNK];
                    if (cnt == LAST_SLICE) begin
                        cout_reg <= slice_add[CHUNK];
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CHUNK_SERIAL_ADDER_OVERFLOW_EN
    logic ovf_reg;

    // Signed overflow is decided on the top slice: operands of equal sign
    // producing a result of the other sign. slice_add[CHUNK-1] is the result
    // MSB during the last RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && cnt == LAST_SLICE) begin
            ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (slice_add[CHUNK-1] != a_reg[WIDTH-1]);
        end
    end

    assign bus.overflow = ovf_reg;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_serial_adder
//
// Purpose: directed self-checking bench for chunked_serial_adder. Two
// instances are exercised: WIDTH=32/CHUNK=8 (four slices) and WIDTH=8/CHUNK=8
// (single slice). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_chunked_serial_adder;
    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

`ifdef CHUNK_SERIAL_ADDER_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    chunked_serial_adder_if #(.WIDTH(32)) bus32 ();
    chunked_serial_adder_if #(.WIDTH(8))  bus8 ();

    chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // Hard stop so the run always ends even if the DUT locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which = 0 drives the 32-bit instance, 1 the 8-bit instance.
    task automatic applyStimulus(input int which, input logic valid,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 input logic oready);
        if (which == 0) begin
            bus32.in_valid  = valid;
            bus32.a         = a;
            bus32.b         = b;
            bus32.cin       = cin;
            bus32.sub       = sub;
            bus32.out_ready = oready;
        end else begin
            bus8.in_valid  = valid;
            bus8.a         = a[7:0];
            bus8.b         = b[7:0];
            bus8.cin       = cin;
            bus8.sub       = sub;
            bus8.out_ready = oready;
        end
    endtask

    function automatic logic [31:0] rdSum(input int which);
        return (which == 0) ? bus32.sum : {24'h0, bus8.sum};
    endfunction

    function automatic logic rdReady(input int which);
        return (which == 0) ? bus32.in_ready : bus8.in_ready;
    endfunction

    function automatic logic rdValid(input int which);
        return (which == 0) ? bus32.out_valid : bus8.out_valid;
    endfunction

    function automatic logic rdCout(input int which);
        return (which == 0) ? bus32.cout : bus8.cout;
    endfunction

    function automatic logic rdOvf(input int which);
        return (which == 0) ? bus32.overflow : bus8.overflow;
    endfunction

    // Issue one operation, scramble the inputs after the accept edge, check
    // latency and results, and optionally consume the result.
    task automatic runOp(input int which, input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub,
                         input logic [31:0] expSum, input logic expCout,
                         input logic expOvf, input bit consume);
        int lat;
        int nchunk;
        nchunk = (which == 0) ? 4 : 1;
        applyStimulus(which, 1'b1, a, b, cin, sub, 1'b0);
        tick();
        applyStimulus(which, 1'b0, ~a, ~b, ~cin, ~sub, 1'b0);
        checkOutput({tag, " in_ready after accept"}, rdReady(which), 0);
        lat = 0;
        while (!rdValid(which) && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, lat, nchunk);
        checkOutput({tag, " sum"}, rdSum(which), expSum);
        checkOutput({tag, " cout"}, rdCout(which), expCout);
        checkOutput({tag, " overflow"}, rdOvf(which), expOvf);
        if (consume) begin
            applyStimulus(which, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            tick();
            applyStimulus(which, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            checkOutput({tag, " in_ready after consume"}, rdReady(which), 1);
            checkOutput({tag, " out_valid after consume"}, rdValid(which), 0);
        end
    endtask

    initial begin
        logic sawValid;

        // Reset, with a request presented during reset that must be ignored.
        rst = 1'b1;
        applyStimulus(0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset in_ready", bus32.in_ready, 1);
        checkOutput("reset out_valid", bus32.out_valid, 0);
        checkOutput("reset sum", bus32.sum, 32'h0);
        checkOutput("reset cout", bus32.cout, 0);
        checkOutput("reset overflow", bus32.overflow, 0);
        checkOutput("reset8 in_ready", bus8.in_ready, 1);
        checkOutput("reset8 out_valid", bus8.out_valid, 0);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("post-reset in_ready", bus32.in_ready, 1);
        checkOutput("post-reset out_valid", bus32.out_valid, 0);

        $display("[TB] 32-bit directed operations");
        runOp(0, "add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runOp(0, "inter-slice carry", 32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0,
              32'h0100_0000, 1'b0, 1'b0, 1'b1);
        runOp(0, "add cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
              32'h2345_678A, 1'b0, 1'b0, 1'b1);
        runOp(0, "sub borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
              32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        runOp(0, "sub no borrow", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1,
              32'h0000_0002, 1'b1, 1'b0, 1'b1);
        runOp(0, "add signed ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
              32'h8000_0000, 1'b0, OVF_EN, 1'b1);
        runOp(0, "sub signed ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
              32'h7FFF_FFFF, 1'b1, OVF_EN, 1'b1);

        $display("[TB] 32-bit backpressure");
        runOp(0, "backpressure", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0,
              32'h0000_0030, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0);
            tick();
            checkOutput("hold out_valid", bus32.out_valid, 1);
            checkOutput("hold sum", bus32.sum, 32'h0000_0030);
            checkOutput("hold cout", bus32.cout, 0);
            checkOutput("hold in_ready", bus32.in_ready, 0);
        end
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("release in_ready", bus32.in_ready, 1);
        checkOutput("release out_valid", bus32.out_valid, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            sawValid |= bus32.out_valid;
        end
        checkOutput("ignored request stays idle", sawValid, 0);

        $display("[TB] 32-bit reset mid-operation");
        applyStimulus(0, 1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort in_ready", bus32.in_ready, 1);
        checkOutput("abort out_valid", bus32.out_valid, 0);
        checkOutput("abort sum", bus32.sum, 32'h0);
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            sawValid |= bus32.out_valid;
        end
        checkOutput("abort never emits", sawValid, 0);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        runOp(0, "after abort", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0,
              32'h0000_0003, 1'b0, 1'b0, 1'b1);

        $display("[TB] 8-bit single-slice operations");
        runOp(1, "n1 add wrap", 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
        runOp(1, "n1 add cin", 32'h12, 32'h34, 1'b1, 1'b0, 32'h47, 1'b0, 1'b0, 1'b1);
        runOp(1, "n1 sub borrow", 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b1);
        runOp(1, "n1 sub no borrow", 32'h07, 32'h05, 1'b0, 1'b1, 32'h02, 1'b1, 1'b0, 1'b1);
        runOp(1, "n1 signed ovf", 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, OVF_EN, 1'b1);

        // With one slice RUN lasts a single cycle, so the abort lands in DONE.
        applyStimulus(1, 1'b1, 32'h21, 32'h12, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("n1 abort in_ready", bus8.in_ready, 1);
        checkOutput("n1 abort out_valid", bus8.out_valid, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            sawValid |= bus8.out_valid;
        end
        checkOutput("n1 abort never emits", sawValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
